// File: rtl/sub_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_operand_sequencer_if
// Brief    : Switch/button inputs, subtractor operand/result bus and status.
// Revision : 1.0
// ============================================================================
interface sub_operand_sequencer_if;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] res_in;
    logic [3:0] flags_in;
    logic [3:0] res_q;
    logic [3:0] flags_q;
    logic [1:0] state_q;
    logic       valid;

    modport master (
        output sw, btn, res_in, flags_in,
        input  a_out, b_out, res_q, flags_q, state_q, valid
    );

    modport slave (
        input  sw, btn, res_in, flags_in,
        output a_out, b_out, res_q, flags_q, state_q, valid
    );
endinterface
`default_nettype wire

// File: rtl/sub_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sub_operand_sequencer
// Brief    : Debounced-button sequencer loading A/B into a 4-bit subtractor
//            and latching its result and flags.
// Revision : 1.0
// ============================================================================
module sub_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sub_operand_sequencer_if.slave bus
);

    localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic       sync_meta;
    logic       sync_btn;
    logic [7:0] deb_cnt;
    logic       press;

    state_t     state, state_nxt;
    logic [3:0] a_q, a_nxt;
    logic [3:0] b_q, b_nxt;
    logic [3:0] res_r, res_nxt;
    logic [3:0] flags_r, flags_nxt;
    logic       valid_r, valid_nxt;

    // press fires only on the increment that lands on DEB_MAX; saturation
    // keeps a held button from firing again until sync_btn drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_btn  <= 1'b0;
            deb_cnt   <= 8'd0;
            press     <= 1'b0;
        end else begin
            sync_meta <= bus.btn;
            sync_btn  <= sync_meta;
            press     <= 1'b0;
            if (!sync_btn) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 8'd1;
                press   <= (deb_cnt == DEB_MAX - 8'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            res_r   <= 4'd0;
            flags_r <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            res_r   <= res_nxt;
            flags_r <= flags_nxt;
            valid_r <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        res_nxt   = res_r;
        flags_nxt = flags_r;
        valid_nxt = valid_r;
        case (state)
            LOAD_A: begin
                if (press) begin
                    a_nxt     = bus.sw;
                    b_nxt     = 4'd0;
                    valid_nxt = 1'b0;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_nxt     = bus.sw;
                    state_nxt = EXEC;
                end
            end
            // Operands have been stable a full cycle; press is ignored here.
            EXEC: begin
                res_nxt   = bus.res_in;
                flags_nxt = bus.flags_in;
                valid_nxt = 1'b1;
                state_nxt = SHOW;
            end
            SHOW: begin
                if (press) begin
                    valid_nxt = 1'b0;
                    state_nxt = LOAD_A;
                end
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.res_q   = res_r;
    assign bus.flags_q = flags_r;
    assign bus.state_q = state;
    assign bus.valid   = valid_r;

endmodule
`default_nettype wire
